// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host receiver.
// FSM state enum, frame geometry, default tuning values, parity helper.
package ps2_pkg;

  localparam int PS2_DATA_BITS      = 8;
  localparam int PS2_FRAME_BITS     = 11;
  localparam int PS2_CLK_FILTER_DEF = 8;
  localparam int PS2_TIMEOUT_DEF    = 50000;
  localparam int PS2_FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // Odd parity holds when data plus parity bit has an odd number of ones.
  function automatic logic odd_parity_ok(
    input logic [PS2_DATA_BITS-1:0] d,
    input logic                     p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-FF synchronizers for ps2_clk/ps2_dat, a glitch
// filter on the clock and a falling-edge pulse.
// Ports: clk_i, rst_i (async, active high), ps2_clk_i, ps2_dat_i in;
//        fall_o (1-cycle pulse), dat_o (synchronized data) out.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int CLK_FILTER = PS2_CLK_FILTER_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic fall_o,
  output logic dat_o
);

  localparam int CW = $clog2(CLK_FILTER + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_flt_q, clk_flt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A new level must persist CLK_FILTER cycles; any return to the
  // accepted level restarts the count.
  always_comb begin
    clk_flt_d = clk_flt_q;
    cnt_d     = '0;
    fall_d    = 1'b0;
    if (clk_sync_q[1] != clk_flt_q) begin
      if (cnt_q == CW'(CLK_FILTER - 1)) begin
        clk_flt_d = clk_sync_q[1];
        fall_d    = clk_flt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_flt_q  <= 1'b1;
      cnt_q      <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_flt_q  <= clk_flt_d;
      cnt_q      <= cnt_d;
      fall_q     <= fall_d;
    end
  end

  assign fall_o = fall_q;
  assign dat_o  = dat_sync_q[1];

endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: PS/2 host receiver; frames in on ps2_clk/ps2_dat, bytes
// out on rx_data/rx_valid/rx_ready, error pulses, busy.
// Storage: one holding register, or a FIFO when PS2_RX_FIFO_EN is set.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FILTER     = PS2_CLK_FILTER_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF,
  parameter int FIFO_DEPTH     = PS2_FIFO_DEPTH_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DB = PS2_DATA_BITS;

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PS2_FRAME_BITS != DB + 3) begin : g_bad_cfg
    $error("ps2_host_rx: bad FIFO_DEPTH or frame size");
  end

  logic fall;
  logic dat;

  ps2_sync_filter #(
    .CLK_FILTER(CLK_FILTER)
  ) u_filt (
    .clk_i    (CLOCK_50),
    .rst_i    (reset),
    .ps2_clk_i(ps2_clk),
    .ps2_dat_i(ps2_dat),
    .fall_o   (fall),
    .dat_o    (dat)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [DB-1:0] sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q;
  logic          push;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    push    = 1'b0;
    // to_q counts cycles elapsed since the most recent fall.
    if (state_q == IDLE) to_d = '0;
    else                 to_d = to_q + 1'b1;
    if (fall) to_d = TW'(1);

    unique case (state_q)
      IDLE: begin
        if (fall && !dat) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (fall) begin
          sh_d  = {dat, sh_q[DB-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'(DB - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          // Parity wins over stop so a frame raises one error at most.
          if (!odd_parity_ok(sh_q, par_q)) perr_d = 1'b1;
          else if (!dat)                   ferr_d = 1'b1;
          else                             push   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !fall &&
        to_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      to_q    <= to_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  logic pop;

`ifdef PS2_RX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  logic [DB-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q;
  logic          full;
  logic          wr_en;

  assign rx_valid = (cnt_q != '0);
  assign rx_data  = mem_q[rd_q];
  assign pop      = rx_valid & rx_ready;
  assign full     = (cnt_q == NW'(FIFO_DEPTH));
  // A full FIFO still takes a push when the head leaves this cycle.
  assign wr_en    = push & (~full | pop);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= sh_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      ovr_q <= push & ~wr_en;
    end
  end
`else
  logic [DB-1:0] hold_q;
  logic          hold_v_q;

  assign rx_valid = hold_v_q;
  assign rx_data  = hold_q;
  assign pop      = hold_v_q & rx_ready;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (push) begin
        if (!hold_v_q || pop) begin
          hold_q   <= sh_q;
          hold_v_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (pop) begin
        hold_v_q <= 1'b0;
      end
    end
  end
`endif

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/ps2_host_rx.md
# ps2_host_rx

Host-side PS/2 receiver that accepts serial frames from a keyboard (such as the bench's `PS2_keyboard` model) on `ps2_clk`/`ps2_dat`. It delivers each received scan-code byte over a valid/ready handshake. It sits inside `top`, between the PS/2 pins and the user logic that decodes scan codes. It filters the device clock, validates start, parity and stop bits, and recovers from stalled frames by timeout.

## Interface
- `CLK_FILTER`, 8: consecutive `CLOCK_50` cycles the synchronized `ps2_clk` must hold a new level before it is accepted.
- `TIMEOUT_CYCLES`, 50000: idle cycles (1 ms at 50 MHz) allowed between falling edges inside a frame.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two. Used only when `PS2_RX_FIFO_EN` is defined.
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  PS/2 clock from the device; asynchronous to `CLOCK_50`.
- `ps2_dat`  in  1  PS/2 data from the device; asynchronous to `CLOCK_50`.
- `rx_data`  out  8  received byte.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts the byte this cycle.
- `parity_err`  out  1  one-cycle pulse when a frame is dropped for bad odd parity.
- `frame_err`  out  1  one-cycle pulse when a frame has a bad stop bit or times out.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because storage is full.
- `busy`  out  1  high while a frame is in progress (state is not IDLE).

## Operation
- `ps2_clk` and `ps2_dat` each pass through a 2-FF synchronizer. `ps2_clk` is then glitch-filtered by a counter that must reach `CLK_FILTER`.
- A filtered 1→0 transition of `ps2_clk` is a falling edge (`fall`). On each `fall`, the synchronized `ps2_dat` is sampled.
- Frame format, 11 bits: start = 0, 8 data bits LSB first, odd parity, stop = 1.
- FSM states and transitions:
  - IDLE: `fall` with dat=0 → DATA, bit counter cleared. `fall` with dat=1 → stay in IDLE, no error.
  - DATA: each `fall` shifts dat into the shift register's bit 7, shifting right. After the 8th bit → PARITY.
  - PARITY: on `fall`, store the parity bit → STOP.
  - STOP: on `fall`, evaluate the frame, then → IDLE:
    - XOR of the 8 data bits and the parity bit = 0 → `parity_err` pulse, byte discarded.
    - Else if dat=0 → `frame_err` pulse, byte discarded. Parity is checked before stop, so only one error pulses per frame.
    - Else the byte is pushed to storage.
- Timeout: a counter clears on every `fall` and increments while state is not IDLE. Reaching `TIMEOUT_CYCLES` → `frame_err` pulse, state → IDLE, partial byte discarded.
- Handshake: a byte is consumed when `rx_valid && rx_ready`. `rx_data` is stable while `rx_valid=1 && rx_ready=0`.
- Reset at any time, including mid-frame: FSM → IDLE and all counters, storage, filters and outputs return to reset values. The rest of the interrupted frame is then handled by the IDLE rules and times out.

## Timing
- Reset values: `rx_data`=0x00; `rx_valid`, `parity_err`, `frame_err`, `overrun`, `busy` = 0. Synchronizers and the filtered clock reset to 1.
- Input latency: 2 synchronizer cycles plus `CLK_FILTER` cycles from a pin edge to `fall`.
- `rx_valid` rises on the cycle after the `fall` that samples the stop bit, unless storage is full.
- Error and overrun pulses assert in that same cycle and last exactly one cycle.
- `busy` rises the cycle after the start-bit `fall`. It falls together with the frame result or the timeout.

## Configuration
- `PS2_RX_FIFO_EN` undefined:
  - Storage is a single holding register.
  - A completed byte arriving while `rx_valid=1` and `rx_ready=0` is dropped with an `overrun` pulse; `rx_data` is unchanged.
  - A push in the same cycle as a pop is accepted.
- `PS2_RX_FIFO_EN` defined:
  - Storage is a `FIFO_DEPTH`-entry FIFO with first-word fall-through. `rx_valid` = not empty; `rx_data` = head entry.
  - A push when full and not popping → `overrun` pulse, byte dropped.
  - Simultaneous push and pop when full: both succeed and the count is unchanged.

## Structure
- Package `ps2_pkg`: FSM state enum (IDLE, DATA, PARITY, STOP), `PS2_DATA_BITS`=8, `PS2_FRAME_BITS`=11, and the default filter and timeout constants.
- Sub-module `ps2_sync_filter`: synchronizer, glitch filter and falling-edge detector. Outputs `fall` and the synchronized dat.
- FIFO or holding register, FSM and timeout counter stay in `ps2_host_rx`.

## Test plan
- Clean frame for 0x1C (parity 0, stop 1), `rx_ready`=1 → `rx_valid` for one cycle with `rx_data`=0x1C; no error pulses.
- Sequence 0xF0 (parity 1) then 0x1C, `rx_ready` held 0 until both frames finish:
  - Without FIFO: `rx_data` stays 0xF0 and `overrun` pulses once.
  - With FIFO: 0xF0 then 0x1C pop in order.
- Frame 0x1C with parity bit 1 → one `parity_err` pulse, `rx_valid` stays 0, `busy` returns to 0.
- Frame 0x29 with stop bit 0 → one `frame_err` pulse, no byte delivered.
- Clock stops after 5 data bits → `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last `fall`. A following 0x29 frame is received correctly.
- Assert `reset` mid-frame, and separately drive `ps2_clk` glitches shorter than `CLK_FILTER` → outputs return to reset values, glitches produce no `fall`, and the next clean frame 0x1C is received.
